// File: rtl/l2_icache_pkg.sv
// Shared types and address helpers for the l2_icache direct-mapped instruction cache.
package l2_pkg;

  localparam int LINE_W  = 128;
  localparam int LADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REFILL   = 2'd1,
    DONE     = 2'd2,
    PREFETCH = 2'd3
  } state_e;

  // Index is the low `off` bits of the line address.
  function automatic logic [LADDR_W-1:0] addr_index(input logic [LADDR_W-1:0] addr, input int off);
    return addr & ((28'd1 << off) - 28'd1);
  endfunction

  function automatic logic [LADDR_W-1:0] addr_tag(input logic [LADDR_W-1:0] addr, input int off);
    return addr >> off;
  endfunction

endpackage

// File: rtl/l2_icache_line_store.sv
// Valid/tag/data arrays of l2_icache: one combinational lookup port, one synchronous fill port.
module l2_line_store
  import l2_pkg::*;
#(
  parameter int NUM_OF_BLOCK = 64,
  parameter int BLOCK_OFFSET = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LADDR_W-1:0] rd_addr,
  output logic               rd_hit,
  output logic [LINE_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [LADDR_W-1:0] wr_addr,
  input  logic [LINE_W-1:0]  wr_data
);

  localparam int TAG_W = LADDR_W - BLOCK_OFFSET;

  logic [NUM_OF_BLOCK-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]        tag_q  [NUM_OF_BLOCK];
  logic [LINE_W-1:0]       data_q [NUM_OF_BLOCK];

  logic [BLOCK_OFFSET-1:0] rd_idx_s, wr_idx_s;
  logic [TAG_W-1:0]        rd_tag_s, wr_tag_s;

  assign rd_idx_s = BLOCK_OFFSET'(addr_index(rd_addr, BLOCK_OFFSET));
  assign rd_tag_s = TAG_W'(addr_tag(rd_addr, BLOCK_OFFSET));
  assign wr_idx_s = BLOCK_OFFSET'(addr_index(wr_addr, BLOCK_OFFSET));
  assign wr_tag_s = TAG_W'(addr_tag(wr_addr, BLOCK_OFFSET));

  assign rd_hit  = valid_q[rd_idx_s] && (tag_q[rd_idx_s] == rd_tag_s);
  assign rd_data = data_q[rd_idx_s];

  // Valid bit set on fill.
  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_idx_s] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits are the only array state that reset clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data storage.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx_s]  <= wr_tag_s;
      data_q[wr_idx_s] <= wr_data;
    end
  end

endmodule

// File: rtl/l2_icache.sv
// l2_icache: direct-mapped read-only L2 instruction cache (hit/refill FSM, registered outputs).
// Define L2I_PREFETCH_EN to enable the next-line prefetch after each demand miss.
module l2_icache
  import l2_pkg::*;
#(
  parameter int NUM_OF_BLOCK = 64,
  parameter int BLOCK_OFFSET = 6
) (
  input  logic               clk,
  input  logic               proc_reset_n,
  input  logic               l1_read,
  input  logic [LADDR_W-1:0] l1_addr,
  output logic [LINE_W-1:0]  l1_rdata,
  output logic               l1_ready,
  output logic               mem_read,
  output logic [LADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0]  mem_rdata,
  input  logic               mem_ready
);

  state_e             state_q, state_d;
  logic               l1_ready_q, l1_ready_d;
  logic [LINE_W-1:0]  l1_rdata_q, l1_rdata_d;
  logic               mem_read_q, mem_read_d;
  logic [LADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic [LADDR_W-1:0] lookup_addr_s;
  logic               hit_s;
  logic [LINE_W-1:0]  hit_data_s;
  logic               fill_s;

`ifdef L2I_PREFETCH_EN
  logic               from_refill_q, from_refill_d;
  logic [LADDR_W-1:0] pf_addr_s;

  // mem_addr_q still holds the refilled line A while in DONE.
  assign pf_addr_s     = mem_addr_q + 28'd1;
  assign lookup_addr_s = (state_q == DONE) ? pf_addr_s : l1_addr;
`else
  assign lookup_addr_s = l1_addr;
`endif

  assign fill_s = mem_ready && ((state_q == REFILL) || (state_q == PREFETCH));

  l2_line_store #(
    .NUM_OF_BLOCK(NUM_OF_BLOCK),
    .BLOCK_OFFSET(BLOCK_OFFSET)
  ) u_store (
    .clk     (clk),
    .rst_n   (proc_reset_n),
    .rd_addr (lookup_addr_s),
    .rd_hit  (hit_s),
    .rd_data (hit_data_s),
    .wr_en   (fill_s),
    .wr_addr (mem_addr_q),
    .wr_data (mem_rdata)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    l1_ready_d = 1'b0;
    l1_rdata_d = l1_rdata_q;
    mem_read_d = mem_read_q;
    mem_addr_d = mem_addr_q;
`ifdef L2I_PREFETCH_EN
    from_refill_d = from_refill_q;
`endif
    case (state_q)
      IDLE: begin
        if (l1_read) begin
          if (hit_s) begin
            l1_ready_d = 1'b1;
            l1_rdata_d = hit_data_s;
            state_d    = DONE;
`ifdef L2I_PREFETCH_EN
            from_refill_d = 1'b0;
`endif
          end else begin
            mem_read_d = 1'b1;
            mem_addr_d = l1_addr;
            state_d    = REFILL;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REFILL: begin
        if (mem_ready) begin
          l1_ready_d = 1'b1;
          l1_rdata_d = mem_rdata;
          mem_read_d = 1'b0;
          state_d    = DONE;
`ifdef L2I_PREFETCH_EN
          from_refill_d = 1'b1;
`endif
        end else begin
          state_d = REFILL;
        end
      end
      DONE: begin
`ifdef L2I_PREFETCH_EN
        from_refill_d = 1'b0;
        if (from_refill_q && !hit_s) begin
          mem_read_d = 1'b1;
          mem_addr_d = pf_addr_s;
          state_d    = PREFETCH;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      PREFETCH: begin
`ifdef L2I_PREFETCH_EN
        if (mem_ready) begin
          mem_read_d = 1'b0;
          state_d    = IDLE;
        end else begin
          state_d = PREFETCH;
        end
`else
        mem_read_d = 1'b0;
        state_d    = IDLE;
`endif
      end
      default: begin
        mem_read_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q    <= IDLE;
      l1_ready_q <= 1'b0;
      l1_rdata_q <= '0;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
`ifdef L2I_PREFETCH_EN
      from_refill_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      l1_ready_q <= l1_ready_d;
      l1_rdata_q <= l1_rdata_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
`ifdef L2I_PREFETCH_EN
      from_refill_q <= from_refill_d;
`endif
    end
  end

  assign l1_ready = l1_ready_q;
  assign l1_rdata = l1_rdata_q;
  assign mem_read = mem_read_q;
  assign mem_addr = mem_addr_q;

endmodule
